instr_fetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues one-outstanding-request reads to instruction memory over a req/ack handshake, so the memory may take any number of cycles to answer. Fetched {pc, instr} pairs are buffered in a FIFO and presented to the decode side with valid/ready. A taken-branch redirect from the execute side flushes the queue and squashes any in-flight read.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StHold   = 2'd2,
    StSquash = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} pairs with flush; head entry read straight from storage registers.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [31:0]     push_pc_i,
  input  logic [31:0]     push_instr_i,
  output logic            valid_o,
  output logic [31:0]     head_pc_o,
  output logic [31:0]     head_instr_o,
  output logic [CntW-1:0] count_o
);

  logic [31:0]     pc_q    [Depth];
  logic [31:0]     instr_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign do_push = push_i && !flush_i && (count_q < CntW'(Depth));
  assign do_pop  = pop_i && !flush_i && valid_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pc_q[PtrW'(i)]    <= '0;
        instr_q[PtrW'(i)] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) begin
        pc_q[wptr_q]    <= push_pc_i;
        instr_q[wptr_q] <= push_instr_i;
      end
    end
  end

  assign head_pc_o    = pc_q[rptr_q];
  assign head_instr_o = instr_q[rptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-outstanding imem reads and buffers results for decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     squash_addr_q, squash_addr_d;
  logic [31:0]     redirect_target;
  logic [CntW-1:0] fifo_count, count_after;
  logic            push, pop, space_ok;

  assign redirect_target = align_word(redirect_pc_i);

  // Redirect wins over both queue operations; the FIFO flush handles the count.
  assign push = (state_q == StReq) && imem_ack_i && !redirect_i;
  assign pop  = id_valid_o && id_ready_i && !redirect_i;

  always_comb begin
    count_after = fifo_count;
    if (push && !pop) begin
      count_after = fifo_count + CntW'(1);
    end else if (pop && !push) begin
      count_after = fifo_count - CntW'(1);
    end
  end

  assign space_ok = (count_after < CntW'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    squash_addr_d = squash_addr_q;
    case (state_q)
      StIdle: begin
        if (redirect_i) fetch_pc_d = redirect_target;
        if (start_i)    state_d    = StReq;
      end
      StReq: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
          // An unanswered request must still complete at its original address.
          if (!imem_ack_i) begin
            state_d       = StSquash;
            squash_addr_d = fetch_pc_q;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = space_ok ? StReq : StHold;
        end
      end
      StHold: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
          state_d    = StReq;
        end else if (space_ok) begin
          state_d = StReq;
        end
      end
      StSquash: begin
        if (redirect_i) fetch_pc_d = redirect_target;
        if (imem_ack_i) state_d    = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      squash_addr_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      squash_addr_q <= squash_addr_d;
    end
  end

  assign imem_req_o  = (state_q == StReq) || (state_q == StSquash);
  assign imem_addr_o = (state_q == StSquash) ? squash_addr_q : fetch_pc_q;

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_i),
    .flush_i      (redirect_i),
    .push_i       (push),
    .pop_i        (pop),
    .push_pc_i    (fetch_pc_q),
    .push_instr_i (imem_rdata_i),
    .valid_o      (id_valid_o),
    .head_pc_o    (id_pc_o),
    .head_instr_o (id_instr_o),
    .count_o      (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirects, PC wrap and reset.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, start_i, imem_ack_i, redirect_i, id_ready_i;
  logic [31:0] imem_rdata_i, redirect_pc_i;
  logic        imem_req_o, id_valid_o;
  logic [31:0] imem_addr_o, id_pc_o, id_instr_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start_i       = 1'b0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = INSTR_NOP;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i    = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  // Leaves the caller in the first cycle with imem_req_o high.
  task automatic start_fetch;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_i = 1'b0;
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %0h exp 0", imem_addr_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", id_valid_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h exp 0", id_pc_o); end
    checks++; if (id_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %0h exp 0", id_instr_o); end
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_no_start got %0h exp 0", imem_req_o); end
  endtask

  task automatic test_stream;
    do_reset();
    id_ready_i = 1'b1;
    start_fetch();
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL stream_req0 got %0h exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL stream_addr0 got %0h exp 0", imem_addr_o); end
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hC0DE_0000;
    tick();
    checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL stream_addr4 got %0h exp 4", imem_addr_o); end
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid got %0h exp 1", id_valid_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL stream_pc0 got %0h exp 0", id_pc_o); end
    checks++; if (id_instr_o !== 32'hC0DE_0000) begin errors++; $display("FAIL stream_instr0 got %0h exp c0de0000", id_instr_o); end
    imem_rdata_i = 32'hC0DE_0004;
    tick();
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL stream_addr8 got %0h exp 8", imem_addr_o); end
    checks++; if (id_pc_o !== 32'h4) begin errors++; $display("FAIL stream_pc4 got %0h exp 4", id_pc_o); end
    checks++; if (id_instr_o !== 32'hC0DE_0004) begin errors++; $display("FAIL stream_instr4 got %0h exp c0de0004", id_instr_o); end
    imem_rdata_i = 32'hC0DE_0008;
    tick();
    checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL stream_addr12 got %0h exp c", imem_addr_o); end
    checks++; if (id_pc_o !== 32'h8) begin errors++; $display("FAIL stream_pc8 got %0h exp 8", id_pc_o); end
    imem_ack_i = 1'b0;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got %0h exp 0", id_valid_o); end
    checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL stream_addr_hold got %0h exp c", imem_addr_o); end
  endtask

  task automatic test_hold;
    do_reset();
    start_fetch();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h1111_0000;
    tick();
    checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL hold_addr4 got %0h exp 4", imem_addr_o); end
    imem_rdata_i = 32'h1111_0004;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req_full got %0h exp 0", imem_req_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL hold_head got %0h exp 0", id_pc_o); end
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req_stay got %0h exp 0", imem_req_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL hold_resume_req got %0h exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL hold_resume_addr got %0h exp 8", imem_addr_o); end
    checks++; if (id_pc_o !== 32'h4) begin errors++; $display("FAIL hold_pop_pc got %0h exp 4", id_pc_o); end
    checks++; if (id_instr_o !== 32'h1111_0004) begin errors++; $display("FAIL hold_pop_instr got %0h exp 11110004", id_instr_o); end
  endtask

  task automatic test_redirect_squash;
    do_reset();
    id_ready_i = 1'b1;
    start_fetch();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h2222_0000;
    tick();
    imem_ack_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL squash_old_addr got %0h exp 4", imem_addr_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL squash_flush got %0h exp 0", id_valid_o); end
    tick();
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL squash_req got %0h exp 1", imem_req_o); end
    tick();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL squash_new_addr got %0h exp 100", imem_addr_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL squash_dropped got %0h exp 0", id_valid_o); end
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL squash_wait got %0h exp 0", id_valid_o); end
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h3333_0100;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (id_pc_o !== 32'h100) begin errors++; $display("FAIL squash_target_pc got %0h exp 100", id_pc_o); end
    checks++; if (id_instr_o !== 32'h3333_0100) begin errors++; $display("FAIL squash_target_instr got %0h exp 33330100", id_instr_o); end
  endtask

  task automatic test_redirect_ack_pop;
    do_reset();
    start_fetch();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h4444_0000;
    tick();
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL rap_pre_valid got %0h exp 1", id_valid_o); end
    imem_rdata_i = 32'h4444_0004;
    id_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick();
    idle_inputs();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rap_flush got %0h exp 0", id_valid_o); end
    checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL rap_addr got %0h exp 200", imem_addr_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rap_req got %0h exp 1", imem_req_o); end
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rap_no_push got %0h exp 0", id_valid_o); end
  endtask

  task automatic test_pc_wrap;
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL wrap_idle_req got %0h exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_idle_addr got %0h exp fffffffc", imem_addr_o); end
    start_fetch();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h5555_AAAA;
    id_ready_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %0h exp 0", imem_addr_o); end
    checks++; if (id_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %0h exp fffffffc", id_pc_o); end
  endtask

  task automatic test_async_reset;
    do_reset();
    start_fetch();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h6666_0000;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %0h exp 1", id_valid_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL areset_req got %0h exp 0", imem_req_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %0h exp 0", id_valid_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL areset_addr got %0h exp 0", imem_addr_o); end
    tick();
    rst_i = 1'b1;
    tick();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h7777_0000;
    tick();
    imem_ack_i = 1'b0;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL late_ack_push got %0h exp 0", id_valid_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL late_ack_req got %0h exp 0", imem_req_o); end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_redirect_squash();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
